rr_arb_n: RTL and testbench
===========================

// Module: rr_arb_n
// PURPOSE
//   N-way round-robin arbiter for a shared single-owner resource, e.g. a bus or memory port.
//   Grants are mutually exclusive and registered.
//   Each grant is held while its requester keeps its request high, up to a tenure limit of MAX_HOLD cycles.
//   One dead cycle is inserted between any two grants, so grants never overlap or sit back-to-back on the resource.
//   Sits between the requesting masters and the resource mux; grant_id drives the mux select.
// PARAMETERS
//   N        4   number of requesters, N >= 2
//   IDW      2   width of grant_id, equal to clog2(N)
//   MAX_HOLD 16  maximum cycles one grant may stay high; 0 = unlimited tenure
// PORTS
//   clk          input   1    clock; all state updates on posedge clk
//   reset        input   1    synchronous, active-high reset
//   request      input   N    level request per requester; held high until granted and for as long as the owner needs the resource
//   grant        output  N    registered one-hot grant, all-zero when no owner
//   grant_valid  output  1    registered; equals |grant
//   grant_id     output  IDW  index of the current owner; holds the last winner while grant_valid=0
//   expired      output  1    one-cycle pulse: grant was revoked because tenure reached MAX_HOLD
// BEHAVIOUR
//   Reset (at posedge clk with reset=1), from any state, including mid-grant:
//     state=IDLE, grant=0, grant_valid=0, grant_id=0, expired=0, hold_cnt=0, last_winner=N-1.
//     So requester 0 has first priority after reset.
//   Arbitration function (combinational):
//     scan request from index (last_winner+1)%N upward, wrapping modulo N; the first set bit wins.
//     The most recent owner therefore has lowest priority.
//   State machine: IDLE, GRANT, GAP.
//   IDLE
//     - request==0: stay in IDLE.
//     - else: next edge grant[w]=1, grant_id=w, last_winner=w, hold_cnt=1, go to GRANT.
//     - Latency: a request sampled at edge k gives a grant visible after edge k (one cycle).
//   GRANT, owner o = grant_id
//     - request[o]==0: next edge grant=0, go to GAP, expired stays 0.
//     - else if MAX_HOLD!=0 and hold_cnt==MAX_HOLD: next edge grant=0, expired=1 for one cycle, go to GAP.
//     - else: hold the grant, hold_cnt+=1.
//     - A request drop coinciding with tenure expiry counts as a normal release: expired=0.
//     - hold_cnt is clog2(MAX_HOLD+1) bits wide, saturating; it is never compared when MAX_HOLD=0.
//     - Changes on non-owner request bits have no effect in GRANT.
//   GAP (exactly one cycle, grant=0)
//     - request==0: go to IDLE.
//     - else: arbitrate exactly as in IDLE and go to GRANT.
//     - Minimum spacing: owner A last high at cycle c, next owner high at cycle c+2.
//     - An expired owner still requesting is re-granted only if no other request is present.
//   Invariants: $onehot0(grant) always; grant_valid==|grant; expired only in the cycle right after a GRANT->GAP transition.
//   Requests dropped before being granted are legal and simply forgotten; no request is queued.
// TESTING (N=4, MAX_HOLD=4 unless stated)
//   1. Reset, then request=4'b0001 held 3 cycles then dropped:
//      grant=0001 one cycle after the request, for 3 cycles; then one GAP cycle; then IDLE; expired never 1.
//   2. Reset, then request=4'b1111 held constantly:
//      owners 0,1,2,3,0 in order, each exactly 4 cycles, 1-cycle gap between owners, expired pulses at each revoke.
//   3. Owner 2 drops its request in the same cycle hold_cnt==4:
//      grant drops after that edge, expired stays 0, next owner is taken from index 3 upward.
//   4. Request=4'b0010 only, held 12 cycles:
//      grant 0010 for 4 cycles, then a gap with an expired pulse, repeated; the sole requester is re-granted each time.
//   5. Reset asserted mid-grant (owner 1):
//      after that edge grant=0, grant_valid=0, grant_id=0, expired=0.
//      After release, request=4'b1010 -> requester 1 wins first (priority scan from index 0).
//   6. MAX_HOLD=0 build, request=4'b0001 held 100 cycles:
//      grant held continuously for all 100 cycles, expired never asserts.

Source files
------------

// File: rtl/rr_arb_n.sv
// N-way round-robin arbiter with registered one-hot grants, a tenure limit and
// a mandatory one-cycle dead gap between consecutive owners.
module rr_arb_n #(
    parameter int N        = 4,
    parameter int IDW      = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   request,
    output logic [N-1:0]   grant,
    output logic           grant_valid,
    output logic [IDW-1:0] grant_id,
    output logic           expired
);

    localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t         r_state;
    logic [N-1:0]   r_grant;
    logic           r_valid;
    logic [IDW-1:0] r_id;
    logic [IDW-1:0] r_last;
    logic [CW-1:0]  r_hold;
    logic           r_expired;

    logic [IDW-1:0] w_win;
    logic [N-1:0]   w_onehot;
    logic           w_any;
    logic           w_tenure_up;

    // Scan starts just after the previous winner, so the latest owner ranks last.
    always_comb begin
        logic           found;
        logic [IDW-1:0] idx;
        found = 1'b0;
        idx   = '0;
        w_win = '0;
        for (int i = 1; i <= N; i++) begin
            idx = IDW'((int'(r_last) + i) % N);
            if (!found && request[idx]) begin
                w_win = idx;
                found = 1'b1;
            end
        end
    end

    assign w_any       = |request;
    assign w_onehot    = N'(1) << w_win;
    assign w_tenure_up = (MAX_HOLD != 0) && (r_hold == CW'(MAX_HOLD));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_valid   <= 1'b0;
            r_id      <= '0;
            r_last    <= IDW'(N - 1);
            r_hold    <= '0;
            r_expired <= 1'b0;
        end else begin
            r_expired <= 1'b0;
            case (r_state)
                IDLE, GAP: begin
                    if (w_any) begin
                        r_grant <= w_onehot;
                        r_valid <= 1'b1;
                        r_id    <= w_win;
                        r_last  <= w_win;
                        r_hold  <= CW'(1);
                        r_state <= GRANT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                GRANT: begin
                    // A release on the expiry cycle wins over expiry, so no pulse.
                    if (!request[r_id]) begin
                        r_grant <= '0;
                        r_valid <= 1'b0;
                        r_state <= GAP;
                    end else if (w_tenure_up) begin
                        r_grant   <= '0;
                        r_valid   <= 1'b0;
                        r_expired <= 1'b1;
                        r_state   <= GAP;
                    end else if (r_hold != {CW{1'b1}}) begin
                        r_hold <= r_hold + CW'(1);
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_valid <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_valid;
    assign grant_id    = r_id;
    assign expired     = r_expired;

endmodule

// File: tb/tb_rr_arb_n.sv
// Directed bench for rr_arb_n: a MAX_HOLD=4 instance for arbitration and tenure,
// plus a MAX_HOLD=0 instance for unlimited tenure.
module tb_rr_arb_n;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   request;
    logic [N-1:0]   grant;
    logic           grant_valid;
    logic [IDW-1:0] grant_id;
    logic           expired;

    logic [N-1:0]   request0;
    logic [N-1:0]   grant0;
    logic           grant_valid0;
    logic [IDW-1:0] grant_id0;
    logic           expired0;

    int checks = 0;
    int errors = 0;

    rr_arb_n #(.N(N), .IDW(IDW), .MAX_HOLD(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .request     (request),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .expired     (expired)
    );

    rr_arb_n #(.N(N), .IDW(IDW), .MAX_HOLD(0)) dut0 (
        .clk         (clk),
        .reset       (reset),
        .request     (request0),
        .grant       (grant0),
        .grant_valid (grant_valid0),
        .grant_id    (grant_id0),
        .expired     (expired0)
    );

    always #5 clk = ~clk;

    // Outputs are sampled 1ns after the rising edge, once registers have settled.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [7:0] got, exp;
        reset    = 1'b1;
        request  = '0;
        request0 = '0;
        tick();
        tick();
        exp = {4'b0000, 1'b0, 2'd0, 1'b0};
        got = {grant, grant_valid, grant_id, expired};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL reset_state: got %b required %b", got, exp);
        end
        got = {grant0, grant_valid0, grant_id0, expired0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL reset_state_unlimited: got %b required %b", got, exp);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_release;
        logic [7:0] got, exp;
        reset = 1'b1; tick(); reset = 1'b0;
        request = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp = {4'b0001, 1'b1, 2'd0, 1'b0};
            got = {grant, grant_valid, grant_id, expired};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL single_hold cycle %0d: got %b required %b", i, got, exp);
            end
        end
        request = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            tick();
            exp = {4'b0000, 1'b0, 2'd0, 1'b0};
            got = {grant, grant_valid, grant_id, expired};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL single_release cycle %0d: got %b required %b", i, got, exp);
            end
        end
    endtask

    task automatic test_rotation;
        logic [7:0] got, exp;
        logic [3:0] oh;
        logic [1:0] id;
        reset = 1'b1; tick(); reset = 1'b0;
        request = 4'b1111;
        for (int o = 0; o < 5; o++) begin
            id = 2'(o % 4);
            oh = 4'b0001 << id;
            for (int c = 0; c < 4; c++) begin
                tick();
                exp = {oh, 1'b1, id, 1'b0};
                got = {grant, grant_valid, grant_id, expired};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("[TB] FAIL rotation owner %0d cycle %0d: got %b required %b", o, c, got, exp);
                end
            end
            tick();
            exp = {4'b0000, 1'b0, id, 1'b1};
            got = {grant, grant_valid, grant_id, expired};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL rotation gap after owner %0d: got %b required %b", o, got, exp);
            end
        end
        request = 4'b0000;
        tick();
        exp = {4'b0000, 1'b0, 2'd0, 1'b0};
        got = {grant, grant_valid, grant_id, expired};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL rotation idle: got %b required %b", got, exp);
        end
    endtask

    task automatic test_drop_at_expiry;
        logic [7:0] got, exp;
        reset = 1'b1; tick(); reset = 1'b0;
        request = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (c == 0) request = 4'b1111;
            exp = {4'b0100, 1'b1, 2'd2, 1'b0};
            got = {grant, grant_valid, grant_id, expired};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL drop_expiry hold cycle %0d: got %b required %b", c, got, exp);
            end
        end
        request = 4'b1011;
        tick();
        exp = {4'b0000, 1'b0, 2'd2, 1'b0};
        got = {grant, grant_valid, grant_id, expired};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL drop_expiry release: got %b required %b", got, exp);
        end
        tick();
        exp = {4'b1000, 1'b1, 2'd3, 1'b0};
        got = {grant, grant_valid, grant_id, expired};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL drop_expiry next_owner: got %b required %b", got, exp);
        end
        request = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_sole_requester;
        logic [7:0] got, exp;
        reset = 1'b1; tick(); reset = 1'b0;
        request = 4'b0010;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k % 5 == 0) exp = {4'b0000, 1'b0, 2'd1, 1'b1};
            else            exp = {4'b0010, 1'b1, 2'd1, 1'b0};
            got = {grant, grant_valid, grant_id, expired};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL sole_requester cycle %0d: got %b required %b", k, got, exp);
            end
        end
        request = 4'b0000;
        tick();
        exp = {4'b0000, 1'b0, 2'd1, 1'b0};
        got = {grant, grant_valid, grant_id, expired};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL sole_requester release: got %b required %b", got, exp);
        end
        tick();
    endtask

    task automatic test_reset_mid_grant;
        logic [7:0] got, exp;
        reset = 1'b1; tick(); reset = 1'b0;
        request = 4'b0010;
        tick();
        tick();
        exp = {4'b0010, 1'b1, 2'd1, 1'b0};
        got = {grant, grant_valid, grant_id, expired};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL mid_grant owner: got %b required %b", got, exp);
        end
        reset = 1'b1;
        tick();
        exp = {4'b0000, 1'b0, 2'd0, 1'b0};
        got = {grant, grant_valid, grant_id, expired};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL mid_grant reset: got %b required %b", got, exp);
        end
        reset   = 1'b0;
        request = 4'b1010;
        tick();
        exp = {4'b0010, 1'b1, 2'd1, 1'b0};
        got = {grant, grant_valid, grant_id, expired};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL mid_grant first_winner: got %b required %b", got, exp);
        end
        request = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_unlimited;
        logic [7:0] got, exp;
        reset = 1'b1; tick(); reset = 1'b0;
        request0 = 4'b0001;
        for (int k = 0; k < 100; k++) begin
            tick();
            exp = {4'b0001, 1'b1, 2'd0, 1'b0};
            got = {grant0, grant_valid0, grant_id0, expired0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL unlimited cycle %0d: got %b required %b", k, got, exp);
            end
        end
        request0 = 4'b0000;
        tick();
        exp = {4'b0000, 1'b0, 2'd0, 1'b0};
        got = {grant0, grant_valid0, grant_id0, expired0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL unlimited release: got %b required %b", got, exp);
        end
    endtask

    initial begin
        reset    = 1'b1;
        request  = '0;
        request0 = '0;
        $display("[TB] starting rr_arb_n tests");
        test_reset();
        test_single_release();
        test_rotation();
        test_drop_at_expiry();
        test_sole_requester();
        test_reset_mid_grant();
        test_unlimited();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
